// File: rtl/tx_realign.sv
// rtl/tx_realign.sv - lane-striped transmit realignment buffer with byte credit tracking
//
// Purpose: Write lines of LANES x LANE_W bits land in one FWFT FIFO per lane.
// The reader consumes any multiple of a lane width per cycle, starting at a
// rotating lane pointer. It can also rotate the head data onto an arbitrary
// destination lane. A byte credit count and a packet-end flag track the data
// the reader may take. Both trail the write by a two-stage pipeline.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush_i               synchronous clear of all data and counters
//   write_ready_o         registered write acceptance
//   write_val_i/dat_i/byte_i/eop_i   write line, lane 0 in MSBs, valid byte count, packet end
//   avail_byte_o          bytes available to the reader
//   avail_eop_o           packet end lies inside the available bytes
//   read_val_i/size_i     consume read_size_i bytes (multiple of a lane width)
//   read_addr_offset_i    destination byte offset (lane field only)
//   read_last_ack_i       end of read burst, returns lane pointer to 0
//   read_dat_o/eop_o      rotated head data and packet-end indication (combinational)
//   err_o                 sticky underflow flag
//
// Build option: TX_REALIGN_UNDERFLOW_CHK_EN enables the underflow check on err_o.
// Without it, err_o is tied to 0.

module tx_realign #(
  parameter int  LANES  = 8,
  parameter int  LANE_W = 64,
  parameter int  DEPTH  = 16,
  localparam int LB     = LANES * LANE_W / 8,
  localparam int LNB    = LANE_W / 8,
  localparam int BW     = $clog2(LB) + 1,
  localparam int AW     = $clog2(LB)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  output logic                    write_ready_o,
  input  logic                    write_val_i,
  input  logic [LANES*LANE_W-1:0] write_dat_i,
  input  logic [BW-1:0]           write_byte_i,
  input  logic                    write_eop_i,
  output logic [15:0]             avail_byte_o,
  output logic                    avail_eop_o,
  input  logic                    read_val_i,
  input  logic [BW-1:0]           read_size_i,
  input  logic [AW-1:0]           read_addr_offset_i,
  input  logic                    read_last_ack_i,
  output logic [LANES*LANE_W-1:0] read_dat_o,
  output logic                    read_eop_o,
  output logic                    err_o
);

  localparam int LG = $clog2(LNB);
  localparam int PW = $clog2(LANES);
  localparam int DW = $clog2(DEPTH);

  // Each entry holds {eop, lane data}.
  typedef logic [LANE_W:0] entry_t;

  entry_t          mem  [LANES][DEPTH];
  logic [DW-1:0]   wptr [LANES];
  logic [DW-1:0]   rptr [LANES];
  logic [DW:0]     cnt  [LANES];
  logic [PW-1:0]   src  [LANES];

  logic            clr;
  logic            wr_go;
  logic            ready;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   addr_lane;
  logic [BW-1:0]   n_pop;
  logic [15:0]     wr_credit;
  logic [15:0]     rd_debit;
  logic [15:0]     credit1, credit2;
  logic [15:0]     avail;
  logic            eop1, eop2;
  logic            avail_eop;
  logic            eop_clear;

  logic [LANES-1:0] push, pop_req, pop, nonempty, head_eop, near_full;

  // Only the lane field of the address offset matters; the byte bits are ignored.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^read_addr_offset_i;

  assign clr       = reset | flush_i;
  assign wr_go     = write_val_i & ready;
  assign n_pop     = read_size_i >> LG;
  assign addr_lane = read_addr_offset_i[AW-1:LG];

  // Credit is rounded up to whole lanes, since a partial lane still occupies an entry.
  assign wr_credit = wr_go ? (((16'(write_byte_i) + 16'(LNB - 1)) >> LG) << LG) : 16'd0;
  assign rd_debit  = read_val_i ? 16'(read_size_i) : 16'd0;

  always_comb begin
    push      = '0;
    pop_req   = '0;
    pop       = '0;
    nonempty  = '0;
    head_eop  = '0;
    near_full = '0;
    for (int i = 0; i < LANES; i++) begin
      nonempty[i]  = (cnt[i] != '0);
      head_eop[i]  = nonempty[i] & mem[i][rptr[i]][LANE_W];
      near_full[i] = (cnt[i] >= (DW+1)'(DEPTH - 3));
      push[i]      = wr_go & (write_byte_i > BW'(i * LNB));
      // Lane i is popped when its distance from rd_ptr (mod LANES) is below n.
      pop_req[i]   = read_val_i & ({{(BW-PW){1'b0}}, PW'(i) - rd_ptr} < n_pop);
      // An empty lane is never popped, so its pointers stay consistent.
      pop[i]       = pop_req[i] & nonempty[i];
    end
  end

  always_comb begin
    read_dat_o = '0;
    for (int j = 0; j < LANES; j++) begin
      src[j] = PW'(j) + rd_ptr - addr_lane;
      read_dat_o[(LANES-1-j)*LANE_W +: LANE_W] = mem[src[j]][rptr[src[j]]][LANE_W-1:0];
    end
  end

  assign read_eop_o    = |head_eop;
  assign eop_clear     = read_val_i & read_eop_o & (16'(read_size_i) == avail);
  assign write_ready_o = ready;
  assign avail_byte_o  = avail;
  assign avail_eop_o   = avail_eop;

  // Storage is not reset; pointer clears make old contents unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) begin
        mem[i][wptr[i]] <= {write_eop_i, write_dat_i[(LANES-1-i)*LANE_W +: LANE_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (clr) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end else begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ready     <= 1'b0;
      rd_ptr    <= '0;
      credit1   <= '0;
      credit2   <= '0;
      avail     <= '0;
      eop1      <= 1'b0;
      eop2      <= 1'b0;
      avail_eop <= 1'b0;
    end else begin
      // Threshold leaves room for the two writes that may already be in flight.
      ready   <= ~|near_full;
      credit1 <= wr_credit;
      credit2 <= credit1;
      avail   <= avail + credit2 - rd_debit;
      eop1    <= wr_go & write_eop_i;
      eop2    <= eop1;
      if (eop2) begin
        avail_eop <= 1'b1;
      end else if (eop_clear) begin
        avail_eop <= 1'b0;
      end
      if (read_last_ack_i) begin
        rd_ptr <= '0;
      end else if (read_val_i) begin
        rd_ptr <= rd_ptr + n_pop[PW-1:0];
      end
    end
  end

`ifdef TX_REALIGN_UNDERFLOW_CHK_EN
  logic err;
  always_ff @(posedge clk) begin
    if (clr) begin
      err <= 1'b0;
    end else if (read_val_i & ((|(pop_req & ~nonempty)) | (16'(read_size_i) > avail))) begin
      err <= 1'b1;
    end
  end
  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tx_realign.sv
// tb/tb_tx_realign.sv - directed table-driven bench for tx_realign

module tb_tx_realign;

  localparam int LANES  = 8;
  localparam int LANE_W = 64;
  localparam int DEPTH  = 16;
  localparam int BW     = 7;
  localparam int AW     = 6;
  localparam int NV     = 23;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush_i;
  logic                    write_ready_o;
  logic                    write_val_i;
  logic [LANES*LANE_W-1:0] write_dat_i;
  logic [BW-1:0]           write_byte_i;
  logic                    write_eop_i;
  logic [15:0]             avail_byte_o;
  logic                    avail_eop_o;
  logic                    read_val_i;
  logic [BW-1:0]           read_size_i;
  logic [AW-1:0]           read_addr_offset_i;
  logic                    read_last_ack_i;
  logic [LANES*LANE_W-1:0] read_dat_o;
  logic                    read_eop_o;
  logic                    err_o;

  int errors = 0;
  int checks = 0;

  tx_realign #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush_i            (flush_i),
    .write_ready_o      (write_ready_o),
    .write_val_i        (write_val_i),
    .write_dat_i        (write_dat_i),
    .write_byte_i       (write_byte_i),
    .write_eop_i        (write_eop_i),
    .avail_byte_o       (avail_byte_o),
    .avail_eop_o        (avail_eop_o),
    .read_val_i         (read_val_i),
    .read_size_i        (read_size_i),
    .read_addr_offset_i (read_addr_offset_i),
    .read_last_ack_i    (read_last_ack_i),
    .read_dat_o         (read_dat_o),
    .read_eop_o         (read_eop_o),
    .err_o              (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [6:0]  wb;
    logic        we;
    int          wid;
    logic        rv;
    logic [6:0]  rs;
    logic [5:0]  ao;
    logic        ack;
    logic        fl;
    logic        x_rdy;
    logic [15:0] x_av;
    logic        x_aeop;
    logic        x_reop;
    int          dlane;
    int          did;
    int          dsrc;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic wv, input int wb, input logic we, input int wid,
                              input logic rv, input int rs, input int ao, input logic ack,
                              input logic fl, input logic x_rdy, input int x_av,
                              input logic x_aeop, input logic x_reop,
                              input int dlane, input int did, input int dsrc);
    vec_t v;
    v.wv = wv; v.wb = 7'(wb); v.we = we; v.wid = wid;
    v.rv = rv; v.rs = 7'(rs); v.ao = 6'(ao); v.ack = ack; v.fl = fl;
    v.x_rdy = x_rdy; v.x_av = 16'(x_av); v.x_aeop = x_aeop; v.x_reop = x_reop;
    v.dlane = dlane; v.did = did; v.dsrc = dsrc;
    return v;
  endfunction

  // Lane k of line id carries {id, k} so every head is identifiable.
  function automatic logic [63:0] lane_val(input int id, input int k);
    return {32'(id), 32'(k)};
  endfunction

  function automatic logic [LANES*LANE_W-1:0] line_val(input int id);
    logic [LANES*LANE_W-1:0] d;
    for (int k = 0; k < LANES; k++) d[(LANES-1-k)*LANE_W +: LANE_W] = lane_val(id, k);
    return d;
  endfunction

  function automatic logic [63:0] out_lane(input int j);
    return read_dat_o[(LANES-1-j)*LANE_W +: LANE_W];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i            = 1'b0;
    write_val_i        = 1'b0;
    write_dat_i        = '0;
    write_byte_i       = '0;
    write_eop_i        = 1'b0;
    read_val_i         = 1'b0;
    read_size_i        = '0;
    read_addr_offset_i = '0;
    read_last_ack_i    = 1'b0;
  endtask

  task automatic drive_write(input int id, input int nbytes, input logic eop);
    write_val_i  = 1'b1;
    write_dat_i  = line_val(id);
    write_byte_i = 7'(nbytes);
    write_eop_i  = eop;
  endtask

  logic exp_err;
  int   acc;

  initial begin
`ifdef TX_REALIGN_UNDERFLOW_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    //              wv wb we id  rv rs ao ack fl  rdy av  aeop reop  dlane did src
    tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,   0, 0,  -1, 0, 0);
    tbl[1]  = mk(1, 64,0, 1,  0, 0, 0, 0, 0,  1, 0,   0, 0,  -1, 0, 0);
    tbl[2]  = mk(1, 64,1, 2,  0, 0, 0, 0, 0,  1, 0,   0, 0,  -1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,   0, 0,   7, 1, 7);
    tbl[4]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 64,  0, 0,  -1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 128, 1, 0,  -1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,  1, 24,0, 0, 0,  1, 128, 1, 0,   0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0,  1, 40,0, 0, 0,  1, 104, 1, 1,   0, 1, 3);
    tbl[8]  = mk(0, 0, 0, 0,  1, 16,0, 0, 0,  1, 64,  1, 1,   0, 2, 0);
    tbl[9]  = mk(0, 0, 0, 0,  0, 0, 16,0, 0,  1, 48,  1, 1,   2, 2, 2);
    tbl[10] = mk(0, 0, 0, 0,  1, 48,0, 0, 0,  1, 48,  1, 1,   0, 2, 2);
    tbl[11] = mk(1, 64,0, 3,  0, 0, 0, 0, 0,  1, 0,   0, 0,  -1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,   0, 0,   5, 3, 5);
    tbl[13] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,   0, 0,  -1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,  1, 16,0, 1, 0,  1, 64,  0, 0,   0, 3, 0);
    tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 48,  0, 0,   2, 3, 2);
    tbl[16] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1,  1, 48,  0, 0,  -1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,   0, 0,  -1, 0, 0);
    tbl[18] = mk(1, 20,1, 4,  0, 0, 0, 0, 0,  1, 0,   0, 0,  -1, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,   0, 1,  -1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,   0, 1,  -1, 0, 0);
    tbl[21] = mk(0, 0, 0, 0,  1, 24,0, 0, 0,  1, 24,  1, 1,   0, 4, 0);
    tbl[22] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,   0, 0,  -1, 0, 0);

    idle();
    reset = 1'b1;
    step();
    step();
    chk("reset ready", 64'(write_ready_o), 64'd0);
    chk("reset avail", 64'(avail_byte_o), 64'd0);
    chk("reset aeop", 64'(avail_eop_o), 64'd0);
    chk("reset err", 64'(err_o), 64'd0);
    chk("reset reop", 64'(read_eop_o), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      flush_i            = tbl[i].fl;
      write_val_i        = tbl[i].wv;
      write_dat_i        = line_val(tbl[i].wid);
      write_byte_i       = tbl[i].wb;
      write_eop_i        = tbl[i].we;
      read_val_i         = tbl[i].rv;
      read_size_i        = tbl[i].rs;
      read_addr_offset_i = tbl[i].ao;
      read_last_ack_i    = tbl[i].ack;
      #1;
      chk($sformatf("c%0d ready", i), 64'(write_ready_o), 64'(tbl[i].x_rdy));
      chk($sformatf("c%0d avail", i), 64'(avail_byte_o), 64'(tbl[i].x_av));
      chk($sformatf("c%0d aeop", i), 64'(avail_eop_o), 64'(tbl[i].x_aeop));
      chk($sformatf("c%0d reop", i), 64'(read_eop_o), 64'(tbl[i].x_reop));
      chk($sformatf("c%0d err", i), 64'(err_o), 64'd0);
      if (tbl[i].dlane >= 0)
        chk($sformatf("c%0d dat lane%0d", i, tbl[i].dlane), out_lane(tbl[i].dlane),
            lane_val(tbl[i].did, tbl[i].dsrc));
      step();
    end
    idle();

    // Fill without reads: ready is registered on occupancy >= 13, so 14 lines get in.
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      drive_write(100 + k, 64, 1'b0);
      #1;
      if (write_ready_o) acc++;
      step();
    end
    idle();
    #1;
    chk("fill accepted", 64'(acc), 64'd14);
    chk("fill ready low", 64'(write_ready_o), 64'd0);
    step(); step(); step(); step();
    chk("fill avail", 64'(avail_byte_o), 64'd896);

    // Drain 13 of the 14 lines; rd_ptr is 3, and full-line reads leave it there.
    for (int k = 0; k < 13; k++) begin
      read_val_i  = 1'b1;
      read_size_i = 7'd64;
      step();
    end
    idle();
    #1;
    chk("drain avail", 64'(avail_byte_o), 64'd64);
    chk("drain ready", 64'(write_ready_o), 64'd1);
    drive_write(200, 64, 1'b1);
    step();
    idle();
    step(); step();
    chk("eop line avail", 64'(avail_byte_o), 64'd128);
    chk("eop line aeop", 64'(avail_eop_o), 64'd1);
    chk("eop line reop", 64'(read_eop_o), 64'd0);
    chk("rot head lane0", out_lane(0), lane_val(113, 3));
    read_val_i  = 1'b1;
    read_size_i = 7'd64;
    step();
    #1;
    chk("last read reop", 64'(read_eop_o), 64'd1);
    chk("last read avail", 64'(avail_byte_o), 64'd64);
    step();
    idle();
    #1;
    chk("drained avail", 64'(avail_byte_o), 64'd0);
    chk("drained aeop", 64'(avail_eop_o), 64'd0);
    chk("drained reop", 64'(read_eop_o), 64'd0);

    // Over-read: 16 bytes requested with only 8 available.
    drive_write(300, 8, 1'b1);
    step();
    idle();
    step(); step();
    chk("small avail", 64'(avail_byte_o), 64'd8);
    read_val_i  = 1'b1;
    read_size_i = 7'd16;
    step();
    idle();
    #1;
    chk("underflow err", 64'(err_o), 64'(exp_err));
    step(); step();
    chk("underflow err held", 64'(err_o), 64'(exp_err));
    chk("pre-flush reop", 64'(read_eop_o), 64'd1);
    chk("pre-flush aeop", 64'(avail_eop_o), 64'd1);
    flush_i = 1'b1;
    step();
    idle();
    #1;
    chk("flush err", 64'(err_o), 64'd0);
    chk("flush avail", 64'(avail_byte_o), 64'd0);
    chk("flush reop", 64'(read_eop_o), 64'd0);
    chk("flush aeop", 64'(avail_eop_o), 64'd0);
    chk("flush ready low", 64'(write_ready_o), 64'd0);
    step();
    chk("flush ready back", 64'(write_ready_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
